// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned, start/busy/done/abort handshake.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand finishes in one cycle instead of WIDTH+2.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned PW = 2 * XW + 1;

`ifdef BOOTH_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic [XW-1:0]    mcand_q, mcand_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [XW-1:0] a_ext_c, b_ext_c;
  logic [PW-1:0] add_a_c, add_s_c, sum_c, step_c;
  logic          zero_op_c;

  // Operand extension to WIDTH+1 bits so the most-negative value can be negated safely.
  always_comb begin
    a_ext_c   = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
    b_ext_c   = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
    zero_op_c = (a == '0) || (b == '0);
  end

  // One Booth iteration: conditional add/subtract of the multiplicand, then arithmetic shift.
  always_comb begin
    add_a_c = {mcand_q, {(XW + 1){1'b0}}};
    add_s_c = {XW'(~mcand_q + XW'(1)), {(XW + 1){1'b0}}};
    case (p_q[1:0])
      2'b01:   sum_c = p_q + add_a_c;
      2'b10:   sum_c = p_q + add_s_c;
      default: sum_c = p_q;
    endcase
    step_c = {sum_c[PW-1], sum_c[PW-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    mcand_d = mcand_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          mcand_d = a_ext_c;
          p_d     = {{XW{1'b0}}, b_ext_c, 1'b0};
          cnt_d   = CNT_W'(XW);
          busy_d  = 1'b1;
          state_d = ST_RUN;
          if (ZERO_SKIP && zero_op_c) begin
            p_d     = '0;
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          p_d   = step_c;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (!abort) begin
          hi_d   = p_q[2*WIDTH:WIDTH+1];
          lo_d   = p_q[WIDTH:1];
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      mcand_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: a WIDTH=32 instance and a WIDTH=8 instance.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start, abort, is_signed;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;

  logic        start8, abort8, is_signed8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8;

  int n_checks = 0;
  int n_pass   = 0;

  booth_mult_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  booth_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .is_signed(is_signed8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; lat counts posedges after the start edge until done is seen.
  // poke_at pulses a junk start mid-run; abort_at pulses abort; busy_ab is busy right after abort.
  task automatic op32(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                      input int poke_at, input int abort_at, input int limit,
                      output int lat, output logic busy_ok, output logic busy_ab);
    is_signed = sgn; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_ok = 1'b1; busy_ab = 1'b1;
    while (!done && lat < limit) begin
      if (lat == abort_at + 1) busy_ab = busy;
      else if (lat <= abort_at && !busy) busy_ok = 1'b0;
      if (lat == poke_at) begin
        start = 1'b1; a = 32'h64; b = 32'h64;
      end else start = 1'b0;
      abort = (lat == abort_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic op8(input logic sgn, input logic [7:0] av, input logic [7:0] bv, output int lat);
    is_signed8 = sgn; a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  localparam int NEVER = 100000;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam int ZERO_LAT8 = 1;
`else
  localparam int ZERO_LAT8 = 10;
`endif

  initial begin
    int   lat;
    logic bok, bab;
    start = 0; abort = 0; is_signed = 0; a = '0; b = '0;
    start8 = 0; abort8 = 0; is_signed8 = 0; a8 = '0; b8 = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // -3 * 7 signed
    op32(1'b1, 32'hFFFF_FFFD, 32'd7, NEVER, NEVER, 200, lat, bok, bab);
    check("t1_lat", 64'(lat), 64'(34));
    check("t1_hi", 64'(hi), 64'hFFFF_FFFF);
    check("t1_lo", 64'(lo), 64'hFFFF_FFEB);
    check("t1_busy_run", 64'(bok), 64'(1));
    check("t1_busy_done", 64'(busy), 64'(0));
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'(0));

    // all-ones squared, unsigned and signed
    op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NEVER, NEVER, 200, lat, bok, bab);
    check("t2u_hi", 64'(hi), 64'hFFFF_FFFE);
    check("t2u_lo", 64'(lo), 64'h0000_0001);
    @(negedge clk);
    op32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NEVER, NEVER, 200, lat, bok, bab);
    check("t2s_hi", 64'(hi), 64'h0);
    check("t2s_lo", 64'(lo), 64'h1);
    @(negedge clk);

    // most-negative squared, then back-to-back start in the done cycle
    op32(1'b1, 32'h8000_0000, 32'h8000_0000, NEVER, NEVER, 200, lat, bok, bab);
    check("t3_hi", 64'(hi), 64'h4000_0000);
    check("t3_lo", 64'(lo), 64'h0);
    check("t3_done", 64'(done), 64'(1));
    op32(1'b1, 32'd2, 32'd3, NEVER, NEVER, 200, lat, bok, bab);
    check("t3b_lat", 64'(lat), 64'(34));
    check("t3b_hi", 64'(hi), 64'h0);
    check("t3b_lo", 64'(lo), 64'h6);
    @(negedge clk);

    // prior result hi/lo = 1/2, then abort at cycle 10
    op32(1'b0, 32'd2, 32'h8000_0001, NEVER, NEVER, 200, lat, bok, bab);
    check("t4_pre_hi", 64'(hi), 64'h1);
    check("t4_pre_lo", 64'(lo), 64'h2);
    @(negedge clk);
    op32(1'b0, 32'd5, 32'd5, 5, 10, 60, lat, bok, bab);
    check("t4_busy_after_abort", 64'(bab), 64'(0));
    check("t4_no_done", 64'(done), 64'(0));
    check("t4_hi", 64'(hi), 64'h1);
    check("t4_lo", 64'(lo), 64'h2);

    // mid-run start ignored: result from the original operands
    @(negedge clk);
    op32(1'b0, 32'd5, 32'd6, 5, NEVER, 200, lat, bok, bab);
    check("t5_lat", 64'(lat), 64'(34));
    check("t5_lo", 64'(lo), 64'd30);
    check("t5_hi", 64'(hi), 64'h0);
    @(negedge clk);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t6_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    check("t6_lo", 64'(lo), 64'd30);

    // async reset mid-operation, then a clean op
    is_signed = 1'b0; a = 32'd11; b = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t7_busy", 64'(busy), 64'(0));
    check("t7_done", 64'(done), 64'(0));
    check("t7_hi", 64'(hi), 64'h0);
    check("t7_lo", 64'(lo), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op32(1'b0, 32'd6, 32'd7, NEVER, NEVER, 200, lat, bok, bab);
    check("t7b_lat", 64'(lat), 64'(34));
    check("t7b_lo", 64'(lo), 64'd42);

    // WIDTH=8: -128 * 127, then zero operand
    @(negedge clk);
    op8(1'b1, 8'h80, 8'h7F, lat);
    check("w8_lat", 64'(lat), 64'(10));
    check("w8_hi", 64'(hi8), 64'hC0);
    check("w8_lo", 64'(lo8), 64'h80);
    @(negedge clk);
    op8(1'b1, 8'h00, 8'h55, lat);
    check("w8z_lat", 64'(lat), 64'(ZERO_LAT8));
    check("w8z_hi", 64'(hi8), 64'h0);
    check("w8z_lo", 64'(lo8), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier for the ALU/execution datapath; serves both MULT (signed) and MULTU (unsigned) from a single unit.
- Explicit start/busy/done handshake and abort input.
- Writes the 2*WIDTH-bit product into hi/lo registers, which hold it until the next completed operation.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64. Product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+2), iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- abort  in  1  cancel the operation in progress.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- a  in  WIDTH  multiplicand; latched with start.
- b  in  WIDTH  multiplier; latched with start.
- busy  out  1  high from the start edge until completion or abort.
- done  out  1  one-cycle pulse in the cycle hi/lo are updated.
- hi  out  WIDTH  product[2*WIDTH-1:WIDTH].
- lo  out  WIDTH  product[WIDTH-1:0].

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk. Under rst: state=IDLE, busy=0, done=0, hi=0, lo=0, internal accumulator and counter cleared.
- Operand extension: a and b are extended to WIDTH+1 bits (sign-extend if is_signed, zero-extend otherwise).
- Datapath:
  - A = {a_ext, zeros}; S = {-a_ext, zeros}; P = {zeros, b_ext, 1'b0}.
  - P width = 2*(WIDTH+1)+1.
  - Each iteration examines P[1:0]: 01 -> P=(P+A)>>>1; 10 -> P=(P+S)>>>1; else P=P>>>1. Shift is arithmetic.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on start && !abort at edge E0: latch operands/mode, load A/S/P, counter=WIDTH+1, busy=1, go to RUN.
  - RUN: one Booth iteration per cycle, counter decrements. Leave RUN on the edge where counter reaches 0 (edges E1..E(WIDTH+1)).
  - DONE: at edge E(WIDTH+2): hi/lo = P[2*WIDTH:1] split hi/lo; done=1 for that single cycle; busy=0; go to IDLE.
- Latency: done high in the cycle after edge E(WIDTH+2), i.e. 34 cycles for WIDTH=32.
- A new start may be sampled in the same cycle done is high (back-to-back supported).
- start while busy: ignored; operands are not re-latched.
- abort while busy (RUN or DONE-pending): next edge returns to IDLE, busy=0, done stays 0, hi/lo retain their previous values.
- abort in IDLE: no effect. start and abort together in IDLE: abort wins, no operation.
- rst mid-operation: immediate return to IDLE; hi=lo=0.
- hi/lo change only on a completed operation or rst.
- Corner cases:
  - Signed most-negative times most-negative: no overflow, because the (WIDTH+1)-bit extension absorbs the negation of the minimum value.
  - Unsigned all-ones times all-ones: exact result.

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined: if a==0 or b==0 when start is sampled at E0, skip RUN. DONE occurs at E1: hi=lo=0, done pulses, busy drops. Total latency 1 cycle.
- Not defined: zero operands take the full WIDTH+2 cycle latency; the result is identical.

Test Plan:
- WIDTH=32, is_signed=1, a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 34 cycles after start; busy high for cycles 1..33.
- WIDTH=32, is_signed=0, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat with is_signed=1 -> hi=0, lo=1.
- WIDTH=32, is_signed=1, a=b=0x80000000 -> hi=0x40000000, lo=0. Immediately issue start in the done cycle with a=2, b=3 -> second result hi=0, lo=6 after a further 34 cycles.
- Prior result hi/lo=0x1/0x2. Start, abort at cycle 10 -> busy=0 next cycle, done never pulses, hi/lo still 0x1/0x2. start pulsed mid-run is ignored.
- Assert rst at cycle 5 of an operation -> busy=0, done=0, hi=lo=0 asynchronously. A new start after rst deasserts completes normally.
- WIDTH=8, is_signed=1, a=0x80 (-128), b=0x7F -> hi=0xC0, lo=0x80, done after 10 cycles. With BOOTH_ZERO_SKIP_EN, a=0, b=0x55 -> done after 1 cycle, hi=lo=0.
